// File: rtl/password_entry_buffer.sv
// Keypad password entry buffer: collects N_DIGITS confirmed digits, supports
// backspace/clear/submit, rejects invalid requests and auto-clears stale entries.
module password_entry_buffer #(
  parameter int N_DIGITS    = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_DIGIT   = 9,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [DIGIT_W-1:0]                  i_digit,
  input  logic                                i_confirm,
  input  logic                                i_backspace,
  input  logic                                i_clear,
  input  logic                                i_submit,
  output logic [N_DIGITS*DIGIT_W-1:0]         o_code,
  output logic                                o_valid,
  output logic [$clog2(N_DIGITS+1)-1:0]       o_count,
  output logic                                o_full,
  output logic                                o_reject,
  output logic                                o_timeout
);

  localparam int BUF_W  = N_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(N_DIGITS + 1);
  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_DIGITS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT_CYC > 0) ? IDLE_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   entryBuf_q, entryBuf_d;
  logic [BUF_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDLE_W-1:0]  idleCnt_q, idleCnt_d;
  logic               valid_q, valid_d;
  logic               full_q, full_d;
  logic               reject_q, reject_d;
  logic               timeout_q, timeout_d;

  logic               anyInput;
  logic               digitOk;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= EMPTY;
      entryBuf_q <= '0;
      code_q     <= '0;
      count_q    <= '0;
      idleCnt_q  <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      reject_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      entryBuf_q <= entryBuf_d;
      code_q     <= code_d;
      count_q    <= count_d;
      idleCnt_q  <= idleCnt_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      reject_q   <= reject_d;
      timeout_q  <= timeout_d;
    end
  end

  assign anyInput = i_clear | i_submit | i_backspace | i_confirm;
  assign digitOk  = (int'({1'b0, i_digit}) <= MAX_DIGIT);

  // Only the highest-priority request acts; lower ones are silently dropped.
  always_comb begin
    entryBuf_d = entryBuf_q;
    code_d     = code_q;
    count_d    = count_q;
    idleCnt_d  = idleCnt_q;
    valid_d    = 1'b0;
    reject_d   = 1'b0;
    timeout_d  = 1'b0;

    if (i_clear) begin
      entryBuf_d = '0;
      count_d    = '0;
    end else if (i_submit) begin
      if (state_q == FULL) begin
        code_d     = entryBuf_q;
        valid_d    = 1'b1;
        entryBuf_d = '0;
        count_d    = '0;
      end else begin
        reject_d = 1'b1;
      end
    end else if (i_backspace) begin
      if (state_q != EMPTY) begin
        entryBuf_d = entryBuf_q >> DIGIT_W;
        count_d    = count_q - CNT_W'(1);
      end else begin
        reject_d = 1'b1;
      end
    end else if (i_confirm) begin
      if (state_q != FULL && digitOk) begin
        entryBuf_d = BUF_W'({entryBuf_q, i_digit});
        count_d    = count_q + CNT_W'(1);
      end else begin
        reject_d = 1'b1;
      end
    end

    // Any request, accepted or not, counts as activity; timeout only clears idle entries.
    if (anyInput || state_q == EMPTY || TIMEOUT_CYC == 0) begin
      idleCnt_d = '0;
    end else if (idleCnt_q == IDLE_LAST) begin
      idleCnt_d  = '0;
      entryBuf_d = '0;
      count_d    = '0;
      timeout_d  = 1'b1;
    end else begin
      idleCnt_d = idleCnt_q + IDLE_W'(1);
    end

    if (count_d == '0) begin
      state_d = EMPTY;
    end else if (count_d == CNT_FULL) begin
      state_d = FULL;
    end else begin
      state_d = PARTIAL;
    end
    full_d = (count_d == CNT_FULL);
  end

  assign o_code    = code_q;
  assign o_valid   = valid_q;
  assign o_count   = count_q;
  assign o_full    = full_q;
  assign o_reject  = reject_q;
  assign o_timeout = timeout_q;

endmodule
